// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for a multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback over one ALU and one
// memory port, resolves branches from N/Z/C/V and traps on illegal opcodes.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   opcode/funct3/funct7b5  instruction register fields
//   N,Z,C,V             live ALU flags (C=1: no borrow)
//   mem_ready           memory handshake
//   mem_req, adr_sel, dmem_wren, ir_wren, pc_wren, regfile_wren
//   alu_asel, alu_bsel, result_sel, ximm_sel, ALU_control
//   instr_retire        pulse on last state of each instruction
//   illegal_instr       high while trapped
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit TRAP_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       N,
  input  logic       Z,
  input  logic       C,
  input  logic       V,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_sel,
  output logic       dmem_wren,
  output logic       ir_wren,
  output logic       pc_wren,
  output logic       regfile_wren,
  output logic [1:0] alu_asel,
  output logic [1:0] alu_bsel,
  output logic [1:0] result_sel,
  output logic [2:0] ximm_sel,
  output logic [3:0] ALU_control,
  output logic       instr_retire,
  output logic       illegal_instr
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_R     = 7'b0110011, OP_I     = 7'b0010011,
                         OP_BR    = 7'b1100011, OP_JAL   = 7'b1101111,
                         OP_JALR  = 7'b1100111, OP_LUI   = 7'b0110111,
                         OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                         ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111, ALU_SRL = 4'b1000,
                         ALU_SRA = 4'b1001;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_EXEC_U, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_TRAP
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       adr_sel;
    logic       dmem_wren;
    logic       ir_wren;
    logic       pc_wren;
    logic       regfile_wren;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic [1:0] result_sel;
    logic [2:0] ximm_sel;
    logic [3:0] alu_ctrl;
    logic       retire;
    logic       illegal;
  } ctrl_t;

  state_e     state_q, state_d;
  ctrl_t      ctrl, ctrl_o;
  logic       ready, taken;
  logic [3:0] alu_rf;
  logic [2:0] ximm;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    ximm = 3'b000;
    case (opcode)
      OP_STORE:         ximm = 3'b001;
      OP_BR:            ximm = 3'b010;
      OP_JAL:           ximm = 3'b011;
      OP_LUI, OP_AUIPC: ximm = 3'b100;
      default:          ximm = 3'b000;
    endcase
  end

  // Only R-type can subtract; shifts pick arithmetic from funct7b5 for R and I.
  always_comb begin
    alu_rf = ALU_ADD;
    case (funct3)
      3'b000: alu_rf = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_rf = ALU_SLL;
      3'b010: alu_rf = ALU_SLT;
      3'b011: alu_rf = ALU_SLTU;
      3'b100: alu_rf = ALU_XOR;
      3'b101: alu_rf = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_rf = ALU_OR;
      default: alu_rf = ALU_AND;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000: taken = Z;
      3'b001: taken = !Z;
      3'b100: taken = N ^ V;
      3'b101: taken = !(N ^ V);
      3'b110: taken = !C;
      3'b111: taken = C;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ctrl          = '0;
    ctrl.alu_ctrl = ALU_ADD;
    ctrl.ximm_sel = ximm;
    state_d       = state_q;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (ready) begin
          ctrl.ir_wren    = 1'b1;
          ctrl.pc_wren    = 1'b1;
          ctrl.bsel       = 2'b10;
          ctrl.result_sel = 2'b10;
          state_d         = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculative branch/JAL target lands in ALUOut.
        ctrl.asel = 2'b01;
        ctrl.bsel = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_EXEC_U;
          default: begin
            if (TRAP_EN) state_d = S_TRAP;
            else begin
              state_d     = S_FETCH;
              ctrl.retire = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.asel = 2'b10;
        ctrl.bsel = 2'b01;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_sel = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.result_sel   = 2'b01;
        ctrl.regfile_wren = 1'b1;
        ctrl.retire       = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.mem_req   = 1'b1;
        ctrl.adr_sel   = 1'b1;
        ctrl.dmem_wren = 1'b1;
        if (ready) begin
          ctrl.retire = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ctrl.asel     = 2'b10;
        ctrl.alu_ctrl = alu_rf;
        state_d       = S_ALUWB;
      end
      S_EXEC_I: begin
        ctrl.asel     = 2'b10;
        ctrl.bsel     = 2'b01;
        ctrl.alu_ctrl = alu_rf;
        state_d       = S_ALUWB;
      end
      S_EXEC_U: begin
        ctrl.asel = (opcode == OP_LUI) ? 2'b11 : 2'b01;
        ctrl.bsel = 2'b01;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.regfile_wren = 1'b1;
        ctrl.retire       = 1'b1;
        state_d           = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.asel     = 2'b10;
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.pc_wren  = taken;
        ctrl.retire   = 1'b1;
        state_d       = S_FETCH;
      end
      S_JALR: begin
        ctrl.asel = 2'b10;
        ctrl.bsel = 2'b01;
        state_d   = S_JAL;
      end
      S_JAL: begin
        // PC <- ALUOut (target) while ALU forms OldPC+4 for the link.
        ctrl.pc_wren = 1'b1;
        ctrl.asel    = 2'b01;
        ctrl.bsel    = 2'b10;
        state_d      = S_ALUWB;
      end
      S_TRAP: ctrl.illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are squashed during reset so nothing leaks while rst_n is low.
  assign ctrl_o = rst_n ? ctrl : '0;

  assign mem_req       = ctrl_o.mem_req;
  assign adr_sel       = ctrl_o.adr_sel;
  assign dmem_wren     = ctrl_o.dmem_wren;
  assign ir_wren       = ctrl_o.ir_wren;
  assign pc_wren       = ctrl_o.pc_wren;
  assign regfile_wren  = ctrl_o.regfile_wren;
  assign alu_asel      = ctrl_o.asel;
  assign alu_bsel      = ctrl_o.bsel;
  assign result_sel    = ctrl_o.result_sel;
  assign ximm_sel      = ctrl_o.ximm_sel;
  assign ALU_control   = ctrl_o.alu_ctrl;
  assign instr_retire  = ctrl_o.retire;
  assign illegal_instr = ctrl_o.illegal;
endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: builds the expected per-cycle control
// trace of each instruction from its phase sequence and compares it with the
// DUT. A second instance (TRAP_EN=0, MEM_HANDSHAKE=0) covers the options.
module tb_multicycle_controller;
  localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_R     = 7'b0110011, OP_I     = 7'b0010011,
                         OP_BR    = 7'b1100011, OP_JAL   = 7'b1101111,
                         OP_JALR  = 7'b1100111, OP_LUI   = 7'b0110111,
                         OP_AUIPC = 7'b0010111;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, N = 1'b0, Z = 1'b0, C = 1'b0, V = 1'b0, mem_ready = 1'b0;

  logic mem_req, adr_sel, dmem_wren, ir_wren, pc_wren, regfile_wren, instr_retire, illegal_instr;
  logic [1:0] alu_asel, alu_bsel, result_sel;
  logic [2:0] ximm_sel;
  logic [3:0] ALU_control;

  logic b_mem_req, b_adr_sel, b_dmem_wren, b_ir_wren, b_pc_wren, b_regfile_wren, b_retire, b_illegal;
  logic [1:0] b_asel, b_bsel, b_rsel;
  logic [2:0] b_ximm;
  logic [3:0] b_alu;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .N(N), .Z(Z), .C(C), .V(V), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_sel(adr_sel), .dmem_wren(dmem_wren), .ir_wren(ir_wren),
    .pc_wren(pc_wren), .regfile_wren(regfile_wren), .alu_asel(alu_asel), .alu_bsel(alu_bsel),
    .result_sel(result_sel), .ximm_sel(ximm_sel), .ALU_control(ALU_control),
    .instr_retire(instr_retire), .illegal_instr(illegal_instr));

  multicycle_controller #(.MEM_HANDSHAKE(1'b0), .TRAP_EN(1'b0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .N(N), .Z(Z), .C(C), .V(V), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .adr_sel(b_adr_sel), .dmem_wren(b_dmem_wren), .ir_wren(b_ir_wren),
    .pc_wren(b_pc_wren), .regfile_wren(b_regfile_wren), .alu_asel(b_asel), .alu_bsel(b_bsel),
    .result_sel(b_rsel), .ximm_sel(b_ximm), .ALU_control(b_alu),
    .instr_retire(b_retire), .illegal_instr(b_illegal));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, adr_sel, dmem_wren, ir_wren, pc_wren, regfile_wren;
    logic [1:0] asel, bsel, rsel;
    logic [3:0] alu;
    logic       retire, illegal;
  } obs_t;

  obs_t exp_q[$];
  logic rdy_q[$];
  int tests = 0, fails = 0;

  function automatic obs_t observe();
    obs_t o;
    o.mem_req = mem_req; o.adr_sel = adr_sel; o.dmem_wren = dmem_wren; o.ir_wren = ir_wren;
    o.pc_wren = pc_wren; o.regfile_wren = regfile_wren; o.asel = alu_asel; o.bsel = alu_bsel;
    o.rsel = result_sel; o.alu = ALU_control; o.retire = instr_retire; o.illegal = illegal_instr;
    return o;
  endfunction

  function automatic logic [2:0] ximm_ref(input logic [6:0] op);
    case (op)
      OP_STORE:         return 3'd1;
      OP_BR:            return 3'd2;
      OP_JAL:           return 3'd3;
      OP_LUI, OP_AUIPC: return 3'd4;
      default:          return 3'd0;
    endcase
  endfunction

  // ALU operation named by the instruction mnemonic table.
  function automatic logic [3:0] alu_ref(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (is_r && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Flags of a-b and the architectural branch outcome from direct comparison.
  logic br_taken;
  task automatic set_operands(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    logic [31:0] d;
    d = a - b;
    N = d[31]; Z = (d == 32'd0); C = (a >= b);
    V = (a[31] != b[31]) && (d[31] != a[31]);
    case (f3)
      3'd0: br_taken = (a == b);
      3'd1: br_taken = (a != b);
      3'd4: br_taken = ($signed(a) < $signed(b));
      3'd5: br_taken = ($signed(a) >= $signed(b));
      3'd6: br_taken = (a < b);
      3'd7: br_taken = (a >= b);
      default: br_taken = 1'b0;
    endcase
  endtask

  task automatic push(input obs_t e, input logic r);
    exp_q.push_back(e); rdy_q.push_back(r);
  endtask

  task automatic push_mem(input obs_t e_wait, input obs_t e_done, input int waits);
    repeat (waits) push(e_wait, 1'b0);
    push(e_done, 1'b1);
  endtask

  // Expected trace of one instruction as a sequence of phases.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input int fw, input int mw, input int trap_cycles);
    obs_t w, d, dec, e;
    exp_q.delete(); rdy_q.delete();
    w = '0; w.mem_req = 1'b1;
    d = w; d.ir_wren = 1'b1; d.pc_wren = 1'b1; d.bsel = 2'd2; d.rsel = 2'd2;
    push_mem(w, d, fw);
    dec = '0; dec.asel = 2'd1; dec.bsel = 2'd1;
    w = '0; w.regfile_wren = 1'b1; w.retire = 1'b1;   // ALU writeback phase
    case (op)
      OP_LOAD, OP_STORE: begin
        push(dec, 1'($urandom));
        e = '0; e.asel = 2'd2; e.bsel = 2'd1; push(e, 1'($urandom));
        e = '0; e.mem_req = 1'b1; e.adr_sel = 1'b1;
        if (op == OP_LOAD) begin
          push_mem(e, e, mw);
          e = '0; e.rsel = 2'd1; e.regfile_wren = 1'b1; e.retire = 1'b1;
          push(e, 1'($urandom));
        end else begin
          e.dmem_wren = 1'b1; d = e; d.retire = 1'b1;
          push_mem(e, d, mw);
        end
      end
      OP_R, OP_I, OP_LUI, OP_AUIPC: begin
        push(dec, 1'($urandom));
        e = '0; e.bsel = (op == OP_R) ? 2'd0 : 2'd1;
        e.asel = (op == OP_LUI) ? 2'd3 : (op == OP_AUIPC) ? 2'd1 : 2'd2;
        if (op == OP_R || op == OP_I) e.alu = alu_ref(op == OP_R, f3, f7);
        push(e, 1'($urandom));
        push(w, 1'($urandom));
      end
      OP_BR: begin
        push(dec, 1'($urandom));
        e = '0; e.asel = 2'd2; e.alu = 4'd1; e.pc_wren = br_taken; e.retire = 1'b1;
        push(e, 1'($urandom));
      end
      OP_JAL, OP_JALR: begin
        push(dec, 1'($urandom));
        if (op == OP_JALR) begin
          e = '0; e.asel = 2'd2; e.bsel = 2'd1; push(e, 1'($urandom));
        end
        e = '0; e.pc_wren = 1'b1; e.asel = 2'd1; e.bsel = 2'd2; push(e, 1'($urandom));
        push(w, 1'($urandom));
      end
      default: begin
        push('0 | dec, 1'($urandom));
        e = '0; e.illegal = 1'b1;
        repeat (trap_cycles) push(e, 1'($urandom));
      end
    endcase
  endtask

  // Step up to n cycles of the expected trace, checking at negedge+1.
  task automatic run_trace(input int n, input string name);
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      @(negedge clk);
      mem_ready = rdy_q[i];
      #1;
      tests++;
      if (observe() !== exp_q[i]) begin
        fails++;
        $display("FAIL %s cyc%0d ctrl: got %h expected %h", name, i, observe(), exp_q[i]);
      end
      tests++;
      if (ximm_sel !== ximm_ref(opcode)) begin
        fails++;
        $display("FAIL %s cyc%0d ximm_sel: got %0d expected %0d", name, i, ximm_sel, ximm_ref(opcode));
      end
    end
  endtask

  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input int fw, input int mw, input string name);
    opcode = op; funct3 = f3; funct7b5 = f7;
    if (op == OP_BR) set_operands($urandom, $urandom, f3);
    else begin N = 1'($urandom); Z = 1'($urandom); C = 1'($urandom); V = 1'($urandom); end
    build(op, f3, f7, fw, mw, 0);
    run_trace(exp_q.size(), name);
  endtask

  // Reset leaves DUT in FETCH with mem_ready low so it waits for the next trace.
  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = OP_STORE; mem_ready = 1'b1;
    @(negedge clk); #1;
    tests++;
    if (observe() !== obs_t'(0) || ximm_sel !== 3'd0) begin
      fails++; $display("FAIL reset_outputs: got %h ximm %0d expected 0", observe(), ximm_sel);
    end
    tests++;
    if ({b_mem_req, b_ir_wren, b_ximm} !== 5'd0) begin
      fails++; $display("FAIL reset_outputs_nt: got %b expected 0", {b_mem_req, b_ir_wren, b_ximm});
    end
    mem_ready = 1'b0; rst_n = 1'b1;
    @(negedge clk); #1;
    tests++;
    if ({mem_req, adr_sel, ir_wren, pc_wren} !== 4'b1000) begin
      fails++; $display("FAIL reset_fetch_wait: got %b expected 1000", {mem_req, adr_sel, ir_wren, pc_wren});
    end
  endtask

  task automatic test_alu_decode();
    do_instr(OP_R, 3'd0, 1'b0, 0, 0, "add");
    do_instr(OP_R, 3'd0, 1'b1, 0, 0, "sub");
    do_instr(OP_I, 3'd0, 1'b1, 0, 0, "addi_f7");
    do_instr(OP_I, 3'd5, 1'b1, 0, 0, "srai");
    do_instr(OP_I, 3'd5, 1'b0, 1, 0, "srli");
    do_instr(OP_R, 3'd3, 1'b0, 0, 0, "sltu");
    do_instr(OP_LUI, 3'd2, 1'b0, 0, 0, "lui");
    do_instr(OP_AUIPC, 3'd7, 1'b1, 2, 0, "auipc");
    do_instr(OP_JAL, 3'd0, 1'b0, 0, 0, "jal");
    do_instr(OP_JALR, 3'd0, 1'b0, 1, 0, "jalr");
  endtask

  task automatic test_branch();
    logic [31:0] a, b;
    opcode = OP_BR;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 5; k++) begin
        a = $urandom;
        case (k)
          0: b = a;
          1: b = a + 32'd1;
          2: begin a = 32'hFFFF_FFFF; b = 32'd0; end           // -1 vs 0
          3: begin a = 32'h8000_0000; b = 32'd1; end           // signed overflow on SUB
          default: b = $urandom;
        endcase
        funct3 = 3'(f); funct7b5 = 1'b0;
        set_operands(a, b, 3'(f));
        build(OP_BR, 3'(f), 1'b0, $urandom_range(0, 1), 0, 0);
        run_trace(exp_q.size(), "branch");
      end
    end
  endtask

  task automatic test_mem_wait();
    do_instr(OP_LOAD, 3'd2, 1'b0, 0, 3, "lw_wait3");
    do_instr(OP_STORE, 3'd2, 1'b0, 0, 2, "sw_wait2");
    do_instr(OP_LOAD, 3'd0, 1'b0, 2, 0, "lb_fwait");
    do_instr(OP_STORE, 3'd0, 1'b1, 1, 0, "sb");
  endtask

  task automatic test_random();
    logic [6:0] ops[9];
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    for (int i = 0; i < 60; i++)
      do_instr(ops[$urandom_range(0, 8)], 3'($urandom), 1'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 3), "random");
  endtask

  task automatic test_trap();
    opcode = 7'b0000000; funct3 = 3'd0; funct7b5 = 1'b0;
    build(opcode, 3'd0, 1'b0, 1, 0, 6);
    run_trace(exp_q.size(), "trap");
    do_reset();
    opcode = 7'b1111111;
    build(opcode, 3'd0, 1'b0, 0, 0, 3);
    run_trace(exp_q.size(), "trap_ff");
  endtask

  task automatic test_trap_disabled();
    opcode = 7'b0000000; rst_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1; #1;
    tests++;
    if ({b_mem_req, b_ir_wren, b_pc_wren} !== 3'b111) begin
      fails++; $display("FAIL nt_fetch_noready: got %b expected 111", {b_mem_req, b_ir_wren, b_pc_wren});
    end
    @(negedge clk); #1;
    tests++;
    if ({b_retire, b_illegal, b_ir_wren, b_regfile_wren} !== 4'b1000) begin
      fails++; $display("FAIL nt_decode_nop: got %b expected 1000", {b_retire, b_illegal, b_ir_wren, b_regfile_wren});
    end
    @(negedge clk); #1;
    tests++;
    if ({b_mem_req, b_ir_wren, b_retire, b_illegal} !== 4'b1100) begin
      fails++; $display("FAIL nt_refetch: got %b expected 1100", {b_mem_req, b_ir_wren, b_retire, b_illegal});
    end
  endtask

  task automatic test_reset_mid_store();
    opcode = OP_STORE; funct3 = 3'd2;
    build(OP_STORE, 3'd2, 1'b0, 0, 2, 0);
    run_trace(4, "sw_pre_reset");
    rst_n = 1'b0; #1;
    tests++;
    if (observe() !== obs_t'(0)) begin
      fails++; $display("FAIL reset_mid_store: got %h expected 0", observe());
    end
    mem_ready = 1'b1;
    @(negedge clk); #1;
    tests++;
    if (observe() !== obs_t'(0)) begin
      fails++; $display("FAIL reset_held: got %h expected 0", observe());
    end
    rst_n = 1'b1; #1;
    tests++;
    if ({mem_req, adr_sel, dmem_wren, ir_wren, pc_wren} !== 5'b10011) begin
      fails++; $display("FAIL reset_release_fetch: got %b expected 10011",
                        {mem_req, adr_sel, dmem_wren, ir_wren, pc_wren});
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_decode();
    test_branch();
    test_mem_wait();
    test_random();
    test_reset_mid_store();
    do_reset();
    test_trap();
    test_trap_disabled();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
